// File: rtl/obi_copy_master_pkg.sv
// Shared types and constants for the OBI block-copy initiator.
// The FSM state encoding lives here so the bench and any wrappers agree on it.
package obi_copy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] BE_FULL    = 4'hF;
  localparam int         WORD_BYTES = 4;

  function automatic logic isAligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

  // Pointers wrap modulo 2^32 on purpose; the 32-bit truncation does that.
  function automatic logic [31:0] nextPtr(input logic [31:0] ptr);
    return ptr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/obi_copy_master_if.sv
// OBI request and response channel bundles used by the copy initiator.
// The request side carries address/data toward the responder; the response side returns rvalid/rdata.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport master (
    output req,
    output we,
    output be,
    output addr,
    output wdata,
    input  gnt
  );

  modport slave (
    input  req,
    input  we,
    input  be,
    input  addr,
    input  wdata,
    output gnt
  );
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output rvalid,
    output rdata
  );

  modport slave (
    input rvalid,
    input rdata
  );
endinterface

// File: rtl/obi_copy_master.sv
// OBI initiator that copies len 32-bit words from src to dst, one transaction at a time.
// Read, wait for rvalid, write, wait for rvalid, repeat; done_o/err_o pulse for one cycle at the end.
module obi_copy_master
  import obi_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  obi_req_if.master        req,
  obi_rsp_if.slave         rsp
);

  state_t           r_state;
  logic [31:0]      r_srcPtr;
  logic [31:0]      r_dstPtr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic             r_err;

  state_t           w_state;
  logic [31:0]      w_srcPtr;
  logic [31:0]      w_dstPtr;
  logic [LEN_W-1:0] w_cnt;
  logic [31:0]      w_buf;
  logic             w_err;
  logic             w_misaligned;

  logic             w_req;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_busy;
  logic             w_done;
  logic             w_errPulse;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_srcPtr <= '0;
      r_dstPtr <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_srcPtr <= w_srcPtr;
      r_dstPtr <= w_dstPtr;
      r_cnt    <= w_cnt;
      r_buf    <= w_buf;
      r_err    <= w_err;
    end
  end

  assign w_misaligned = !isAligned(src_addr_i[1:0]) || !isAligned(dst_addr_i[1:0]);

  always_comb begin
    w_state  = r_state;
    w_srcPtr = r_srcPtr;
    w_dstPtr = r_dstPtr;
    w_cnt    = r_cnt;
    w_buf    = r_buf;
    w_err    = r_err;

    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_srcPtr = src_addr_i;
          w_dstPtr = dst_addr_i;
          w_cnt    = len_i;
          if (w_misaligned) begin
            w_err   = 1'b1;
            w_state = DONE;
          end else if (len_i == '0) begin
            w_err   = 1'b0;
            w_state = DONE;
          end else begin
            w_err   = 1'b0;
            w_state = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (req.gnt) begin
          w_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rsp.rvalid) begin
          w_buf   = rsp.rdata;
          w_state = WR_REQ;
        end
      end
      WR_REQ: begin
        if (req.gnt) begin
          w_state = WR_WAIT;
        end
      end
      // The write response retires one word; rdata on this response carries nothing useful.
      WR_WAIT: begin
        if (rsp.rvalid) begin
          w_srcPtr = nextPtr(r_srcPtr);
          w_dstPtr = nextPtr(r_dstPtr);
          w_cnt    = r_cnt - LEN_W'(1);
          w_state  = (r_cnt == LEN_W'(1)) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        w_err   = 1'b0;
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // Outputs are gated by rst_ni so the bus is quiet in every cycle reset is held low.
  always_comb begin
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_be       = 4'h0;
    w_addr     = '0;
    w_wdata    = '0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_errPulse = 1'b0;

    if (rst_ni) begin
      w_busy = (r_state != IDLE);
      unique case (r_state)
        RD_REQ: begin
          w_req  = 1'b1;
          w_be   = BE_FULL;
          w_addr = r_srcPtr;
        end
        WR_REQ: begin
          w_req   = 1'b1;
          w_we    = 1'b1;
          w_be    = BE_FULL;
          w_addr  = r_dstPtr;
          w_wdata = r_buf;
        end
        DONE: begin
          w_done     = 1'b1;
          w_errPulse = r_err;
        end
        default: begin
        end
      endcase
    end
  end

  assign req.req   = w_req;
  assign req.we    = w_we;
  assign req.be    = w_be;
  assign req.addr  = w_addr;
  assign req.wdata = w_wdata;
  assign busy_o    = w_busy;
  assign done_o    = w_done;
  assign err_o     = w_errPulse;

endmodule

// File: tb/tb_obi_copy_master.sv
// Self-checking bench for obi_copy_master: an SRAM responder with programmable grant stall
// plus a word-level copy model that predicts bus transactions, memory contents and done timing.
module tb_obi_copy_master;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  obi_req_if reqBus ();
  obi_rsp_if rspBus ();

  obi_copy_master #(.LEN_W(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .req        (reqBus),
    .rsp        (rspBus)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mem      [logic [31:0]];
  logic [31:0] modelMem [logic [31:0]];
  txn_t        txnQ     [$];

  int          stallCycles = 0;
  int          stallCnt    = 0;
  bit          holding     = 0;
  bit          pendValid   = 0;
  logic [31:0] pendData    = '0;
  logic        heldWe;
  logic [3:0]  heldBe;
  logic [31:0] heldAddr;
  logic [31:0] heldWdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder: grants after stallCycles waiting cycles, answers rvalid one cycle after the grant.
  always @(negedge clk) begin
    rspBus.rvalid = 1'b0;
    rspBus.rdata  = $urandom;
    if (pendValid) begin
      rspBus.rvalid = 1'b1;
      rspBus.rdata  = pendData;
      pendValid     = 0;
    end
    if (reqBus.req === 1'b1) begin
      if (holding) begin
        checkOutput("stallWe",    32'(reqBus.we),  32'(heldWe));
        checkOutput("stallBe",    32'(reqBus.be),  32'(heldBe));
        checkOutput("stallAddr",  reqBus.addr,     heldAddr);
        checkOutput("stallWdata", reqBus.wdata,    heldWdata);
      end
      if (stallCnt >= stallCycles) begin
        reqBus.gnt = 1'b1;
        stallCnt   = 0;
        holding    = 0;
        checkOutput("txnExpected", 32'(txnQ.size() != 0), 32'd1);
        if (txnQ.size() != 0) begin
          txn_t t;
          t = txnQ.pop_front();
          checkOutput("txnWe",    32'(reqBus.we), 32'(t.we));
          checkOutput("txnAddr",  reqBus.addr,    t.addr);
          checkOutput("txnBe",    32'(reqBus.be), 32'hF);
          checkOutput("txnWdata", reqBus.wdata,   t.wdata);
        end
        if (reqBus.we) begin
          mem[reqBus.addr] = reqBus.wdata;
          pendData = $urandom;
        end else begin
          pendData = mem.exists(reqBus.addr) ? mem[reqBus.addr] : 32'h0;
        end
        pendValid = 1;
      end else begin
        reqBus.gnt = 1'b0;
        stallCnt++;
        if (!holding) begin
          heldWe    = reqBus.we;
          heldBe    = reqBus.be;
          heldAddr  = reqBus.addr;
          heldWdata = reqBus.wdata;
        end
        holding = 1;
      end
    end else begin
      reqBus.gnt = 1'b0;
      stallCnt   = 0;
      holding    = 0;
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    mem[addr]      = data;
    modelMem[addr] = data;
  endtask

  // Word-level copy model: ascending order, so overlapping ranges see already-copied words.
  task automatic planCopy(input logic [31:0] s, input logic [31:0] d, input int len);
    for (int i = 0; i < len; i++) begin
      txn_t        t;
      logic [31:0] ra;
      logic [31:0] wa;
      logic [31:0] data;
      ra   = s + 32'(4 * i);
      wa   = d + 32'(4 * i);
      data = modelMem.exists(ra) ? modelMem[ra] : 32'h0;
      t.we = 1'b0; t.addr = ra; t.wdata = 32'h0;
      txnQ.push_back(t);
      t.we = 1'b1; t.addr = wa; t.wdata = data;
      txnQ.push_back(t);
      modelMem[wa] = data;
    end
  endtask

  task automatic checkMem();
    checkOutput("txnQueueDrained", 32'(txnQ.size()), 32'd0);
    checkOutput("memSize", 32'(mem.num()), 32'(modelMem.num()));
    foreach (modelMem[a]) begin
      checkOutput($sformatf("memWord@%h", a), mem.exists(a) ? mem[a] : 32'hx, modelMem[a]);
    end
  endtask

  // Starts one copy at edge 0 and checks busy/done/err every cycle up to two cycles past done.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int len,
                               input int stall, input bit pulseMid);
    bit misaligned;
    int expDone;
    misaligned  = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    stallCycles = stall;
    if (!misaligned) planCopy(s, d, len);
    expDone = (misaligned || len == 0) ? 1 : 1 + len * (4 + 2 * stall);

    @(negedge clk);
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = 16'(len);
    start_i    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= expDone + 2; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (k == 2) begin
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i      = 16'($urandom);
      end
      checkOutput($sformatf("busy@c%0d", k), 32'(busy_o), 32'(k <= expDone));
      checkOutput($sformatf("done@c%0d", k), 32'(done_o), 32'(k == expDone));
      checkOutput($sformatf("err@c%0d", k),  32'(err_o),  32'((k == expDone) && misaligned));
      if (misaligned || len == 0) checkOutput("noBusReq", 32'(reqBus.req), 32'd0);
      if (pulseMid && k == 3) begin
        start_i    = 1'b1;
        src_addr_i = 32'h0000_0800;
        dst_addr_i = 32'h0000_0900;
        len_i      = 16'd5;
      end
      if (pulseMid && k == 4) start_i = 1'b0;
    end
    checkMem();
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i      = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstBusy",  32'(busy_o),       32'd0);
    checkOutput("rstDone",  32'(done_o),       32'd0);
    checkOutput("rstErr",   32'(err_o),        32'd0);
    checkOutput("rstReq",   32'(reqBus.req),   32'd0);
    checkOutput("rstWe",    32'(reqBus.we),    32'd0);
    checkOutput("rstBe",    32'(reqBus.be),    32'd0);
    checkOutput("rstAddr",  reqBus.addr,       32'd0);
    checkOutput("rstWdata", reqBus.wdata,      32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    $display("[TB] 4-word copy, zero-wait responder");
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
    applyStimulus(32'h100, 32'h200, 4, 0, 0);

    $display("[TB] 2-word copy, 3-cycle grant stall");
    for (int i = 0; i < 2; i++) preload(32'h300 + 32'(4 * i), $urandom);
    applyStimulus(32'h300, 32'h380, 2, 3, 0);

    $display("[TB] zero length and misaligned starts");
    applyStimulus(32'h100, 32'h200, 0, 0, 0);
    applyStimulus(32'h102, 32'h200, 3, 0, 0);
    applyStimulus(32'h100, 32'h201, 3, 0, 0);

    $display("[TB] address wrap with ignored mid-transfer start");
    preload(32'hFFFF_FFFC, 32'hCAFE_0001);
    preload(32'h0000_0000, 32'hCAFE_0002);
    applyStimulus(32'hFFFF_FFFC, 32'h700, 2, 1, 1);

    $display("[TB] overlapping ascending copy");
    for (int i = 0; i < 4; i++) preload(32'h400 + 32'(4 * i), $urandom);
    applyStimulus(32'h400, 32'h404, 3, 0, 0);

    $display("[TB] reset during WR_WAIT of word 2 of 8");
    for (int i = 0; i < 8; i++) preload(32'h500 + 32'(4 * i), $urandom);
    stallCycles = 0;
    planCopy(32'h500, 32'h600, 2);
    @(negedge clk);
    src_addr_i = 32'h500;
    dst_addr_i = 32'h600;
    len_i      = 16'd8;
    start_i    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      checkOutput($sformatf("abortBusy@c%0d", k), 32'(busy_o), 32'd1);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    checkOutput("abortReq",  32'(reqBus.req), 32'd0);
    checkOutput("abortBusy", 32'(busy_o),     32'd0);
    checkOutput("abortDone", 32'(done_o),     32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("postAbortBusy", 32'(busy_o),     32'd0);
    checkOutput("postAbortReq",  32'(reqBus.req), 32'd0);
    checkMem();
    applyStimulus(32'h520, 32'h680, 1, 0, 0);

    $display("[TB] randomized copies");
    for (int r = 0; r < 5; r++) begin
      logic [31:0] s;
      logic [31:0] d;
      int          len;
      s   = 32'h1000 + 32'(r * 32'h100) + {24'h0, 6'($urandom_range(0, 15)), 2'b00};
      d   = 32'h8000 + 32'(r * 32'h100) + {24'h0, 6'($urandom_range(0, 15)), 2'b00};
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) preload(s + 32'(4 * i), $urandom);
      applyStimulus(s, d, len, $urandom_range(0, 2), r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
